// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequencing controller that builds a W x W unsigned multiply-accumulate
//   from a single external 2x2 multiplier (mult2bit). Accepted operands are
//   latched. Every pair of 2-bit digits is then walked through mult2bit, one
//   pair per cycle with the b digit (j) stepping fastest. The shifted 4-bit
//   partials are summed into a 2W-bit product register, and the finished
//   product is added into the accumulator.
//
// Build option:
//   MAC_SAT_EN  defined   -> an accumulate carry out saturates acc to all-ones
//               undefined -> an accumulate carry out wraps modulo 2^ACC_W
//   ovf is set on a carry out in both builds. Cycle timing is identical.
//
// Parameters:
//   W      operand width (even, >= 2)
//   ACC_W  accumulator width (>= 2*W)
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; accept = in_valid && in_ready
//   in_a, in_b        unsigned operands
//   clr_acc           replace (rather than add to) acc for this operation
//   mult_a, mult_b    digit pair driven to mult2bit (0 outside MULT)
//   mult_p            combinational mult2bit product
//   busy              high in MULT and ACC
//   done              one-cycle pulse after the accumulator update
//   acc               accumulator
//   ovf               sticky overflow flag
module mac_seq_ctrl #(
  parameter int W     = 8,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             clr_acc,
  output logic [1:0]       mult_a,
  output logic [1:0]       mult_b,
  input  logic [3:0]       mult_p,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  localparam int ND = W / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    i_q, i_d;
  logic [CW-1:0]    j_q, j_d;
  logic [W-1:0]     a_lat_q, a_lat_d;
  logic [W-1:0]     b_lat_q, b_lat_d;
  logic             clr_lat_q, clr_lat_d;
  logic [2*W-1:0]   prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic [CW:0]      dig_sum;
  logic [2*W-1:0]   part;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   acc_sum;

  // Accumulate with the carry returned in the top bit. Under MAC_SAT_EN a
  // carry clamps the result to all-ones; a saturated acc then stays
  // saturated, because any non-zero add carries again.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc_in,
                                             input logic [2*W-1:0]   prod_in);
    logic [ACC_W:0] ext;
    logic [ACC_W:0] sum;
    ext            = '0;
    ext[2*W-1:0]   = prod_in;
    sum            = {1'b0, acc_in} + ext;
`ifdef MAC_SAT_EN
    if (sum[ACC_W]) begin
      sum = {1'b1, {ACC_W{1'b1}}};
    end
`endif
    return sum;
  endfunction

  // Digit select and partial-product alignment
  always_comb begin
    dig_sum       = {1'b0, i_q} + {1'b0, j_q};
    part          = '0;
    part[3:0]     = mult_p;
    part          = part << {dig_sum, 1'b0};
    prod_ext      = '0;
    prod_ext[2*W-1:0] = prod_q;
    acc_sum       = acc_add(acc_q, prod_q);
  end

  assign mult_a   = (state_q == MULT) ? a_lat_q[{i_q, 1'b0} +: 2] : 2'b00;
  assign mult_b   = (state_q == MULT) ? b_lat_q[{j_q, 1'b0} +: 2] : 2'b00;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == MULT) || (state_q == ACC);
  assign done     = (state_q == DONE);
  assign acc      = acc_q;
  assign ovf      = ovf_q;

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    a_lat_d   = a_lat_q;
    b_lat_d   = b_lat_q;
    clr_lat_d = clr_lat_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_lat_d   = in_a;
          b_lat_d   = in_b;
          clr_lat_d = clr_acc;
          prod_d    = '0;
          i_d       = '0;
          j_d       = '0;
          state_d   = MULT;
        end
      end
      MULT: begin
        prod_d = prod_q + part;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = ACC;
          end else begin
            i_d = i_q + CW'(1);
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      ACC: begin
        if (clr_lat_q) begin
          acc_d = prod_ext;
          ovf_d = 1'b0;
        end else begin
          acc_d = acc_sum[ACC_W-1:0];
          if (acc_sum[ACC_W]) begin
            ovf_d = 1'b1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      j_q       <= '0;
      clr_lat_q <= 1'b0;
      prod_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      clr_lat_q <= clr_lat_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  // Operand latches
  always_ff @(posedge clk) begin
    a_lat_q <= a_lat_d;
    b_lat_q <= b_lat_d;
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
module tb_mac_seq_ctrl;

  localparam int W     = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             clr_acc;
  logic [1:0]       mult_a;
  logic [1:0]       mult_b;
  logic [3:0]       mult_p;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  mac_seq_ctrl #(.W(W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .clr_acc  (clr_acc),
    .mult_a   (mult_a),
    .mult_b   (mult_b),
    .mult_p   (mult_p),
    .busy     (busy),
    .done     (done),
    .acc      (acc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Stand-in for the gate-level 2x2 multiplier
  assign mult_p = {2'b00, mult_a} * {2'b00, mult_b};

  typedef struct {
    longint unsigned acc;
    bit              ovf;
    longint          cyc;
  } exp_t;

  exp_t            sbq[$];
  longint          done_cycs[$];
  longint          cyc = 0;
  int              n_cmp = 0;
  int              n_bad = 0;
  longint unsigned m_acc = 0;
  bit              m_ovf = 1'b0;

  localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: acc is the running sum of a*b since the last clear, with a
  // carry past ACC_W bits either wrapping or clamping.
  task automatic model_op(input longint unsigned a, input longint unsigned b, input bit clr);
    longint unsigned p;
    longint unsigned s;
    p = a * b;
    if (clr) begin
      m_acc = p;
      m_ovf = 1'b0;
    end else begin
      s = m_acc + p;
      if (s >= ACC_MOD) begin
        m_ovf = 1'b1;
`ifdef MAC_SAT_EN
        m_acc = ACC_MOD - 1;
`else
        m_acc = s - ACC_MOD;
`endif
      end else begin
        m_acc = s;
      end
    end
  endtask

  // Monitor: every done pulse pops the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("acc", acc, e.acc);
        chk("ovf", ovf, e.ovf);
        chk("latency", cyc - e.cyc, 18);
        done_cycs.push_back(cyc);
      end
    end
  end

  // Present an operation, wait for the accept edge, record the expectation.
  // Returns 1 time unit after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr, input bit hold);
    exp_t e;
    int   k;
    in_a     = a;
    in_b     = b;
    clr_acc  = clr;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk);
    model_op(a, b, clr);
    e.acc = m_acc;
    e.ovf = m_ovf;
    e.cyc = cyc;
    sbq.push_back(e);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sbq.size() != 0 || !in_ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      chk("idle_timeout", 0, 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_mult_a"}, mult_a, 0);
    chk({tag, "_mult_b"}, mult_b, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] da;
    logic [W-1:0] db;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    clr_acc  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Single op, full-scale operands
    send(8'd255, 8'd255, 1'b1, 1'b0);
    wait_idle();
    chk("single_acc", acc, 65025);

    // Digit walk: distinct digits so ordering (j fastest) is visible
    da = 8'hE4;
    db = 8'h1B;
    send(da, db, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("mult_a_digit", mult_a, (da >> (2 * (k / 4))) & 2'b11);
      chk("mult_b_digit", mult_b, (db >> (2 * (k % 4))) & 2'b11);
      chk("busy_mult", busy, 1);
    end
    @(negedge clk);
    chk("mult_a_acc_state", mult_a, 0);
    chk("mult_b_acc_state", mult_b, 0);
    wait_idle();

    // Accumulate with in_valid held high
    done_cycs.delete();
    send(8'd10, 8'd20, 1'b1, 1'b1);
    send(8'd7, 8'd9, 1'b0, 1'b1);
    send(8'd0, 8'd100, 1'b0, 1'b0);
    wait_idle();
    chk("accum_acc", acc, 263);
    if (done_cycs.size() == 3) begin
      chk("done_spacing_1", done_cycs[1] - done_cycs[0], 19);
      chk("done_spacing_2", done_cycs[2] - done_cycs[1], 19);
    end else begin
      chk("done_count", done_cycs.size(), 3);
    end

    // Clear mid-stream
    send(8'd3, 8'd4, 1'b1, 1'b0);
    wait_idle();
    chk("clear_acc", acc, 12);
    chk("clear_ovf", ovf, 0);

    // Overflow: 17 x 65025 exceeds 2^20
    send(8'd255, 8'd255, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      send(8'd255, 8'd255, 1'b0, 1'b0);
    end
    wait_idle();
`ifdef MAC_SAT_EN
    chk("ovf_acc", acc, 1048575);
`else
    chk("ovf_acc", acc, 56849);
`endif
    chk("ovf_flag", ovf, 1);

    // Handshake: a pulse while busy is ignored
    send(8'd11, 8'd13, 1'b1, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    in_a     = 8'd5;
    in_b     = 8'd6;
    clr_acc  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_acc", acc, 143);
    send(8'd5, 8'd6, 1'b0, 1'b0);
    wait_idle();
    chk("handshake_acc", acc, 173);

    // Reset in MULT cycle 7 discards the operation
    send(8'd200, 8'd100, 1'b0, 1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    sbq.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    chk("acc_after_rst", acc, 0);

    // Randomized operations against the reference model
    for (int n = 0; n < 24; n++) begin
      send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle();
    chk("random_final_acc", acc, m_acc);
    chk("random_final_ovf", ovf, m_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencing controller for the 2x2 gate-level multiplier (mult2bit) to build a W x W unsigned multiply-accumulate.
- Latches two W-bit operands, walks every pair of 2-bit operand digits through one external mult2bit instance (one pair per cycle), then shifts and sums the 4-bit partial products into a 2W-bit product register.
- Adds the finished product into an accumulator.
- Sits between the operand source (valid/ready handshake) and the shared mult2bit datapath.

Parameters:
- W, 8, operand width in bits; must be even and >= 2.
- ACC_W, 20, accumulator width; must be >= 2*W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- in_a  input  W  multiplicand, unsigned
- in_b  input  W  multiplier, unsigned
- clr_acc  input  1  zero the accumulator before this operation's add; sampled with the accepted operands
- mult_a  output  2  digit of latched a driven to mult2bit
- mult_b  output  2  digit of latched b driven to mult2bit
- mult_p  input  4  mult2bit product (combinational return, same cycle)
- busy  output  1  high in MULT and ACC states
- done  output  1  one-cycle pulse when the accumulator has been updated
- acc  output  ACC_W  accumulator value
- ovf  output  1  sticky; set when an accumulate wraps or saturates, cleared by rst or an accepted clr_acc

Behaviour:
- Reset state (rst=1 at a clk edge): state=IDLE, acc=0, ovf=0, done=0, busy=0, in_ready=1, mult_a=0, mult_b=0, digit counters=0, product register=0.
- rst overrides everything, including a mid-operation state; the in-flight operation is discarded.
- States and transitions:
  - IDLE: in_ready=1. An accept is in_valid && in_ready at a clk edge. On accept: latch in_a, in_b and clr_acc; clear the product register; set i=j=0; go to MULT.
  - MULT: in_ready=0, busy=1.
    - mult_a = a_lat[2i+1:2i], mult_b = b_lat[2j+1:2j], driven combinationally from the counters.
    - Each cycle: prod += zero_extend(mult_p) << (2*(i+j)).
    - j increments; on j wrap (j = W/2-1 -> 0), i increments.
    - After the pair i=j=W/2-1, go to ACC. MULT therefore lasts exactly (W/2)^2 cycles (16 for W=8).
  - ACC: busy=1.
    - If clr_acc was latched: acc = zero_extend(prod) and ovf=0.
    - Otherwise: acc = acc + zero_extend(prod), computed at ACC_W+1 bits. A carry out is an overflow: acc wraps modulo 2^ACC_W and ovf=1.
    - Go to DONE.
  - DONE: done=1 for this single cycle, busy=0, in_ready=0; go to IDLE next cycle.
- Latency: accept edge -> done high is (W/2)^2 + 2 cycles (18 for W=8). Back-to-back throughput is one operation per (W/2)^2 + 3 cycles.
- mult_a/mult_b are 0 outside MULT. in_valid, in_a, in_b and clr_acc are ignored outside IDLE.
- Width rules:
  - The product register is 2W bits and can never overflow, since the sum of partials equals a*b.
  - Partial shifts go up to 2*(W-2).
  - acc stays stable between updates.
- Zero operands still take the full cycle count; there is no early exit.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: on an accumulate carry out, acc = 2^ACC_W-1 and ovf=1. Once acc is saturated it stays saturated until clr_acc or rst.
- Undefined: modulo wrap as in Behaviour; ovf is still set.
- Cycle timing is identical in both builds.

Test Plan:
- Reset: hold rst 2 cycles, then release -> acc=0, ovf=0, busy=0, done=0, in_ready=1, mult_a=mult_b=0. Assert rst in MULT cycle 7 -> same reset values the next cycle, and no done pulse.
- Single op: clr_acc=1, a=255, b=255 -> done exactly 18 cycles after accept, acc=65025, ovf=0. mult_a/mult_b step through all 16 digit pairs, j fastest.
- Accumulate: three ops (10,20,clr=1), (7,9,0), (0,100,0) -> acc after each done: 200, 263, 263. Three done pulses spaced 19 cycles apart when in_valid is held high.
- Clear mid-stream: with acc=263, op (3,4,clr=1) -> acc=12, ovf=0.
- Overflow: clr op (255,255), then 16 more (255,255) ops -> acc after the last op: 56849 with ovf=1 (default build), or 1048575 with ovf=1 (MAC_SAT_EN build).
- Handshake: pulse in_valid with a=5, b=6 while busy -> ignored (acc unchanged, no extra done). Then in_valid in IDLE -> accepted and acc += 30.
